spi_xfer_arbiter: RTL and testbench

- Shares one SPI master pin set (ss_pad_o, sclk_pad_o, mosi_pad_o, miso_pad_i) among NUM_REQ internal requesters.
- Performs round-robin arbitration, then sequences one full-duplex DATA_W-bit transfer per grant: SPI mode 0, MSB first.
- Provides the slave-select, SCLK generation and shift sequencing consumed by the slave-side verification interface.

---
 rtl/spi_xfer_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master pin set among NUM_REQ requesters.
// Each grant runs one full-duplex DATA_W-bit mode-0, MSB-first transfer.
module spi_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SS_W    = 8,
    parameter int DIV_W   = 8,
    localparam int SEL_W  = (SS_W > 1) ? $clog2(SS_W) : 1,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_ss_sel,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [DIV_W-1:0]         clk_div,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [DATA_W-1:0]        rdata,
    output logic [SS_W-1:0]          ss_pad_o,
    output logic                     sclk_pad_o,
    output logic                     mosi_pad_o,
    input  logic                     miso_pad_i
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]           state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id_l;
    logic [SEL_W-1:0]     sel_l;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_W-1:0]    tx_sr;
    logic [DATA_W-1:0]    rx_sr;

    logic [2*NUM_REQ-1:0] req2;
    logic [ID_W:0]        rr_sum;
    logic                 pick_vld;
    logic [ID_W-1:0]      pick;
    logic [ID_W-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [DATA_W-1:0]    pick_wdata;
    logic [SEL_W-1:0]     pick_sel;
    logic [SS_W-1:0]      ss_mask;
    logic                 arb_en;
    logic                 half_end;

    // Rotating the doubled request vector by ptr turns the wraparound search into a plain priority scan.
    always_comb begin
        req2     = {req, req} >> ptr;
        rr_sum   = '0;
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld && req2[k]) begin
                pick_vld = 1'b1;
                rr_sum   = {1'b0, ptr} + (ID_W+1)'(k);
                if (rr_sum >= (ID_W+1)'(NUM_REQ))
                    rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
                pick     = rr_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_nxt    = '0;
        pick_wdata = '0;
        pick_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == ID_W'(i)) begin
                gnt_nxt[i] = pick_vld;
                pick_wdata = req_wdata[i*DATA_W +: DATA_W];
                pick_sel   = req_ss_sel[i*SEL_W +: SEL_W];
            end
        end
        ptr_nxt = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end

    // An index with no matching line leaves every select high while the transfer still runs.
    always_comb begin
        ss_mask = '1;
        for (int b = 0; b < SS_W; b++)
            ss_mask[b] = (sel_l != SEL_W'(b));
    end

    // Arbitration also runs in DONE so the next grant can follow without an idle cycle.
    assign arb_en   = ((state == ST_IDLE) && (gnt == '0)) || (state == ST_DONE);
    assign half_end = (cnt == div_l);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            id_l       <= '0;
            sel_l      <= '0;
            div_l      <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            rdata      <= '0;
            ss_pad_o   <= '1;
            sclk_pad_o <= 1'b0;
            mosi_pad_o <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt != '0) begin
                        state      <= ST_SETUP;
                        ss_pad_o   <= ss_mask;
                        mosi_pad_o <= tx_sr[DATA_W-1];
                        cnt        <= '0;
                        bit_cnt    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (half_end) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (!sclk_pad_o) begin
                            sclk_pad_o <= 1'b1;
                            rx_sr      <= {rx_sr[DATA_W-2:0], miso_pad_i};
                            bit_cnt    <= bit_cnt + 1'b1;
                        end else begin
                            sclk_pad_o <= 1'b0;
                            if (bit_cnt == CNT_W'(DATA_W)) begin
                                state <= ST_HOLD;
                            end else begin
                                mosi_pad_o <= tx_sr[DATA_W-2];
                                tx_sr      <= {tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (half_end) begin
                        cnt      <= '0;
                        state    <= ST_DONE;
                        ss_pad_o <= '1;
                        done     <= 1'b1;
                        done_id  <= id_l;
                        rdata    <= rx_sr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (arb_en && pick_vld) begin
                gnt   <= gnt_nxt;
                busy  <= 1'b1;
                id_l  <= pick;
                sel_l <= pick_sel;
                div_l <= clk_div;
                tx_sr <= pick_wdata;
                ptr   <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: mode-0 slave model, transfer scoreboard, per-scenario tasks.
module tb_spi_xfer_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [11:0] req_ss_sel = '0;
    logic [31:0] req_wdata = '0;
    logic [7:0]  clk_div = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [7:0]  rdata;
    logic [7:0]  ss_pad_o;
    logic        sclk_pad_o;
    logic        mosi_pad_o;
    logic        miso = 1'b0;

    spi_xfer_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .req_ss_sel(req_ss_sel),
        .req_wdata(req_wdata), .clk_div(clk_div), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .rdata(rdata), .ss_pad_o(ss_pad_o),
        .sclk_pad_o(sclk_pad_o), .mosi_pad_o(mosi_pad_o), .miso_pad_i(miso)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] rd;
        logic [7:0] wd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] miso_q[$];
    int         gnt_log[$];
    int         done_cnt = 0;

    // Mode-0 slave: first bit on select fall, sample on SCLK rise, shift on SCLK fall.
    wire        ss_act = (ss_pad_o != 8'hFF);
    logic [7:0] slv_sh = '0;
    logic [7:0] slv_rx = '0;
    int         slv_bits = 0;

    always @(posedge ss_act) begin
        slv_sh = 8'h00;
        if (miso_q.size() > 0) slv_sh = miso_q.pop_front();
        miso     = slv_sh[7];
        slv_bits = 0;
        slv_rx   = '0;
    end
    always @(posedge sclk_pad_o) if (ss_act) begin
        slv_rx = {slv_rx[6:0], mosi_pad_o};
        slv_bits++;
    end
    always @(negedge sclk_pad_o) if (ss_act) begin
        slv_sh = {slv_sh[6:0], 1'b0};
        miso   = slv_sh[7];
    end

    int         ss_cnt = 0, ss_len = 0, hi_cnt = 0, hi_len = 0, gap_cnt = 0, min_gap = 1000;
    logic [7:0] ss_val = 8'hFF;

    always @(negedge clock) begin
        exp_t e;
        if (ss_act) begin
            ss_cnt++;
            ss_val = ss_pad_o;
            if (gap_cnt > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
            gap_cnt = 0;
        end else begin
            if (ss_cnt != 0) begin ss_len = ss_cnt; ss_cnt = 0; end
            gap_cnt++;
        end
        if (sclk_pad_o) hi_cnt++;
        else if (hi_cnt != 0) begin hi_len = hi_cnt; hi_cnt = 0; end

        if (gnt != 4'b0) begin
            tests++;
            if ($countones(gnt) != 1) begin
                fails++;
                $display("FAIL gnt_onehot got %b", gnt);
            end
            for (int i = 0; i < 4; i++) if (gnt[i]) gnt_log.push_back(i);
        end

        if (done === 1'b1) begin
            done_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done id=%0d rdata=%h", done_id, rdata);
            end else begin
                e = exp_q.pop_front();
                if (done_id !== e.id) begin
                    fails++;
                    $display("FAIL done_id got %0d exp %0d", done_id, e.id);
                end
                tests++;
                if (rdata !== e.rd) begin
                    fails++;
                    $display("FAIL rdata got %h exp %h", rdata, e.rd);
                end
                tests++;
                if (slv_rx !== e.wd) begin
                    fails++;
                    $display("FAIL mosi_word got %h exp %h", slv_rx, e.wd);
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [2:0] sel, input logic [7:0] wd);
        req_ss_sel[id*3 +: 3] = sel;
        req_wdata[id*8 +: 8]  = wd;
    endtask

    task automatic wait_gnts(input int n, input int budget);
        int t = 0;
        while (gnt_log.size() < n && t < budget) begin @(negedge clock); t++; end
        tests++;
        if (gnt_log.size() < n) begin
            fails++;
            $display("FAIL gnt_timeout got %0d exp %0d", gnt_log.size(), n);
        end
    endtask

    task automatic wait_dones(input int n, input int budget);
        int t = 0;
        while (done_cnt < n && t < budget) begin @(negedge clock); t++; end
        tests++;
        if (done_cnt < n) begin
            fails++;
            $display("FAIL done_timeout got %0d exp %0d", done_cnt, n);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic one_xfer(input int id, input logic [2:0] sel, input logic [7:0] wd,
                            input logic [7:0] rd, input int budget);
        int base = done_cnt;
        exp_q.push_back('{id[1:0], rd, wd});
        miso_q.push_back(rd);
        set_req(id, sel, wd);
        gnt_log.delete();
        req[id] = 1'b1;
        wait_gnts(1, 20);
        req = '0;
        wait_dones(base + 1, budget);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++; if (gnt !== 4'h0)     begin fails++; $display("FAIL reset_gnt got %h exp 0", gnt); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (done_id !== 2'd0) begin fails++; $display("FAIL reset_done_id got %0d exp 0", done_id); end
        tests++; if (rdata !== 8'h00)  begin fails++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        tests++; if (ss_pad_o !== 8'hFF) begin fails++; $display("FAIL reset_ss got %h exp ff", ss_pad_o); end
        tests++; if (sclk_pad_o !== 1'b0) begin fails++; $display("FAIL reset_sclk got %b exp 0", sclk_pad_o); end
        tests++; if (mosi_pad_o !== 1'b0) begin fails++; $display("FAIL reset_mosi got %b exp 0", mosi_pad_o); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        int t = 0;
        int lat = 0;
        clk_div = 8'd1;
        set_req(2, 3'd5, 8'hA5);
        exp_q.push_back('{2'd2, 8'h3C, 8'hA5});
        miso_q.push_back(8'h3C);
        req = 4'b0100;
        while (gnt == 4'b0 && t < 10) begin @(negedge clock); t++; end
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt got %b exp 0100", gnt); end
        tests++; if (busy !== 1'b1)   begin fails++; $display("FAIL single_busy_gnt got %b exp 1", busy); end
        req = 4'b0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
        tests++; if (lat != 37)     begin fails++; $display("FAIL single_latency got %0d exp 37", lat); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_done got %b exp 1", busy); end
        @(negedge clock);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got %b exp 0", busy); end
        @(negedge clock);
        tests++; if (ss_len != 36)    begin fails++; $display("FAIL single_ss_len got %0d exp 36", ss_len); end
        tests++; if (ss_val !== 8'hDF) begin fails++; $display("FAIL single_ss_val got %h exp df", ss_val); end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int dc;
        clk_div = 8'd1;
        set_req(1, 3'd0, 8'h5A);
        miso_q.push_back(8'hFF);
        gnt_log.delete();
        req = 4'b0010;
        wait_gnts(1, 20);
        req = 4'b0;
        @(negedge clock);
        while (slv_bits < 3 && t < 100) begin @(negedge clock); t++; end
        tests++; if (slv_bits < 3) begin fails++; $display("FAIL midrst_sclk_timeout got %0d exp 3", slv_bits); end
        dc = done_cnt;
        #1 reset = 1'b1;
        #1;
        tests++; if (ss_pad_o !== 8'hFF) begin fails++; $display("FAIL midrst_ss got %h exp ff", ss_pad_o); end
        tests++; if (sclk_pad_o !== 1'b0) begin fails++; $display("FAIL midrst_sclk got %b exp 0", sclk_pad_o); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        tests++; if (done_cnt != dc) begin fails++; $display("FAIL midrst_no_done got %0d exp %0d", done_cnt, dc); end
        // Stale pointer would be 2 and pick requester 3; a cleared pointer picks 0.
        set_req(0, 3'd2, 8'h81);
        set_req(3, 3'd7, 8'h7E);
        exp_q.push_back('{2'd0, 8'h96, 8'h81});
        miso_q.push_back(8'h96);
        gnt_log.delete();
        req = 4'b1001;
        wait_gnts(1, 20);
        req = 4'b0;
        tests++;
        if (gnt_log.size() < 1 || gnt_log[0] != 0) begin
            fails++;
            $display("FAIL midrst_first_gnt got %0d exp 0", (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
        wait_dones(dc + 1, 200);
    endtask

    task automatic test_round_robin();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int base;
        pulse_reset();
        clk_div = 8'd0;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'h10 + i));
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back('{2'(exp_ord[n]), 8'(8'hC0 + n), 8'(8'h10 + exp_ord[n])});
            miso_q.push_back(8'(8'hC0 + n));
        end
        gnt_log.delete();
        min_gap = 1000;
        base = done_cnt;
        req = 4'b1111;
        wait_gnts(5, 200);
        req = 4'b0;
        wait_dones(base + 5, 200);
        tests++; if (gnt_log.size() != 5) begin fails++; $display("FAIL rr_count got %0d exp 5", gnt_log.size()); end
        for (int n = 0; n < 5 && n < gnt_log.size(); n++) begin
            tests++;
            if (gnt_log[n] != exp_ord[n]) begin
                fails++;
                $display("FAIL rr_order[%0d] got %0d exp %0d", n, gnt_log[n], exp_ord[n]);
            end
        end
        tests++; if (min_gap < 1) begin fails++; $display("FAIL rr_ss_gap got %0d exp >=1", min_gap); end
    endtask

    task automatic test_ptr_skip();
        int exp_ord[3] = '{1, 3, 0};
        int base = done_cnt;
        int t = 0;
        clk_div = 8'd0;
        set_req(1, 3'd1, 8'h33);
        set_req(3, 3'd3, 8'hCC);
        set_req(0, 3'd4, 8'h0F);
        exp_q.push_back('{2'd1, 8'h11, 8'h33});
        exp_q.push_back('{2'd3, 8'h22, 8'hCC});
        exp_q.push_back('{2'd0, 8'h44, 8'h0F});
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        miso_q.push_back(8'h44);
        gnt_log.delete();
        req = 4'b0010;
        wait_gnts(1, 20);
        req = 4'b1001;
        while (req != 4'b0 && t < 300) begin
            @(negedge clock);
            t++;
            if (gnt[3]) req[3] = 1'b0;
            if (gnt[0]) req[0] = 1'b0;
        end
        req = 4'b0;
        wait_dones(base + 3, 200);
        tests++; if (gnt_log.size() != 3) begin fails++; $display("FAIL skip_count got %0d exp 3", gnt_log.size()); end
        for (int n = 0; n < 3 && n < gnt_log.size(); n++) begin
            tests++;
            if (gnt_log[n] != exp_ord[n]) begin
                fails++;
                $display("FAIL skip_order[%0d] got %0d exp %0d", n, gnt_log[n], exp_ord[n]);
            end
        end
    endtask

    task automatic test_divider();
        clk_div = 8'd0;
        one_xfer(2, 3'd0, 8'hE7, 8'h18, 100);
        tests++; if (ss_len != 18) begin fails++; $display("FAIL div0_ss_len got %0d exp 18", ss_len); end
        tests++; if (hi_len != 1)  begin fails++; $display("FAIL div0_half got %0d exp 1", hi_len); end
        clk_div = 8'hFF;
        one_xfer(1, 3'd6, 8'h69, 8'hB4, 6000);
        tests++; if (ss_len != 4608) begin fails++; $display("FAIL divff_ss_len got %0d exp 4608", ss_len); end
        tests++; if (hi_len != 256)  begin fails++; $display("FAIL divff_half got %0d exp 256", hi_len); end
    endtask

    task automatic test_div_change();
        int base = done_cnt;
        int t = 0;
        clk_div = 8'd3;
        set_req(0, 3'd3, 8'hF0);
        exp_q.push_back('{2'd0, 8'h5B, 8'hF0});
        miso_q.push_back(8'h5B);
        gnt_log.delete();
        req = 4'b0001;
        wait_gnts(1, 20);
        req = 4'b0;
        @(negedge clock);
        while (slv_bits < 2 && t < 200) begin @(negedge clock); t++; end
        clk_div = 8'd0;
        wait_dones(base + 1, 200);
        tests++; if (ss_len != 72) begin fails++; $display("FAIL divchg_ss_len got %0d exp 72", ss_len); end
        tests++; if (hi_len != 4)  begin fails++; $display("FAIL divchg_half got %0d exp 4", hi_len); end
        one_xfer(2, 3'd1, 8'h0D, 8'hD0, 100);
        tests++; if (ss_len != 18) begin fails++; $display("FAIL divnext_ss_len got %0d exp 18", ss_len); end
        tests++; if (hi_len != 1)  begin fails++; $display("FAIL divnext_half got %0d exp 1", hi_len); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mid_reset();
        test_round_robin();
        test_ptr_skip();
        test_divider();
        test_div_change();
        repeat (5) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected got %0d exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
